// File: rtl/karatsuba_gf2_mult_seq.sv
// Sequential one-level Karatsuba carry-less multiplier that time-shares a single P x P GF(2) multiplier.
// Optional MOD_REDUCE_EN adds a RED state that folds the product modulo POLY into a W-bit result.
module karatsuba_gf2_mult_seq #(
    parameter int             W    = 41,
    parameter logic [W:0]     POLY = 42'h200_0000_0009
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MOD_REDUCE_EN
    output logic [W-1:0]     C
`else
    output logic [2*W-2:0]   C
`endif
);

    // state  | meaning
    // IDLE   | waiting for operands, in_ready=1
    // MUL_L  | computing L = Al*Bl
    // MUL_H  | computing H = Ah*Bh
    // MUL_M  | computing M and recombining the full product
    // RED    | folding the product modulo POLY (MOD_REDUCE_EN only)
    // DONE   | result held on C until out_ready

    localparam int P   = (W + 1) / 2;
    localparam int HW  = W - P;
    localparam int PW  = 2 * P - 1;
    localparam int PRW = 2 * W - 1;
`ifdef MOD_REDUCE_EN
    localparam int CW  = W;
`else
    localparam int CW  = PRW;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL_L = 3'd1,
        MUL_H = 3'd2,
        MUL_M = 3'd3,
        RED   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic [PW-1:0]   l_q, l_d, h_q, h_d;
    logic [CW-1:0]   c_q, c_d;
`ifdef MOD_REDUCE_EN
    logic [PRW-1:0]  p_q, p_d;
`endif

    logic [P-1:0]    al, bl, ah, bh;
    logic [P-1:0]    mul_x, mul_y;
    logic [PW-1:0]   mul_r;
    logic [PW-1:0]   mid;
    logic [PRW-1:0]  prod;

    function automatic logic [PW-1:0] clmul_p(input logic [P-1:0] x, input logic [P-1:0] y);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < P; i++) begin
            if (y[i]) r = r ^ (PW'(x) << i);
        end
        return r;
    endfunction

`ifdef MOD_REDUCE_EN
    function automatic logic [W-1:0] reduce(input logic [PRW-1:0] p);
        logic [PRW-1:0] r;
        r = p;
        for (int i = PRW - 1; i >= W; i--) begin
            if (r[i]) r = r ^ (PRW'(POLY) << (i - W));
        end
        return r[W-1:0];
    endfunction
`endif

    assign al = a_q[P-1:0];
    assign bl = b_q[P-1:0];
    assign ah = P'(a_q[W-1:P]);
    assign bh = P'(b_q[W-1:P]);

    // The single shared multiplier; operands selected by the current phase.
    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            MUL_L: begin mul_x = al;      mul_y = bl;      end
            MUL_H: begin mul_x = ah;      mul_y = bh;      end
            MUL_M: begin mul_x = al ^ ah; mul_y = bl ^ bh; end
            default: ;
        endcase
    end

    assign mul_r = clmul_p(mul_x, mul_y);
    assign mid   = mul_r ^ h_q ^ l_q;
    assign prod  = (PRW'(h_q) << (2 * P)) ^ (PRW'(mid) << P) ^ PRW'(l_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        l_d     = l_q;
        h_d     = h_q;
        c_d     = c_q;
`ifdef MOD_REDUCE_EN
        p_d     = p_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = MUL_L;
                end
            end
            MUL_L: begin
                l_d     = mul_r;
                state_d = MUL_H;
            end
            MUL_H: begin
                h_d     = mul_r;
                state_d = MUL_M;
            end
            MUL_M: begin
`ifdef MOD_REDUCE_EN
                p_d     = prod;
                state_d = RED;
`else
                c_d     = prod;
                state_d = DONE;
`endif
            end
            RED: begin
`ifdef MOD_REDUCE_EN
                c_d     = reduce(p_q);
`endif
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            l_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
`ifdef MOD_REDUCE_EN
            p_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            l_q     <= l_d;
            h_q     <= h_d;
            c_q     <= c_d;
`ifdef MOD_REDUCE_EN
            p_q     <= p_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign C         = c_q;

endmodule
